// File: rtl/nib_pkg.sv
// Shared types for the NIB-to-RAM bridge: response source, in-flight read tag,
// and the data returned for misaligned reads.
package nib_pkg;

  typedef enum logic {
    SRC_PC = 1'b0,
    SRC_EX = 1'b1
  } src_e;

  typedef struct packed {
    logic vld;
    src_e src;
    logic zero;
  } tag_t;

  localparam logic [31:0] MISALIGN_RDATA = 32'h0;

endpackage

// File: rtl/nib_rsp_pipe.sv
// Delays a read tag by the RAM latency and steers RAM read data to the port
// that issued the read. Each port's rdata holds its last value between strobes.
module nib_rsp_pipe
  import nib_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  tag_t        tag_i,
  input  logic [31:0] mem_rdata_i,
  output logic        pc_rvalid_o,
  output logic [31:0] pc_rdata_o,
  output logic        ex_rvalid_o,
  output logic [31:0] ex_rdata_o
);

  tag_t [RD_LAT-1:0] tag_q;
  tag_t              tag_out;
  logic [31:0]       rsp_data;
  logic [31:0]       pc_hold_q;
  logic [31:0]       ex_hold_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out     = tag_q[RD_LAT-1];
  assign rsp_data    = tag_out.zero ? MISALIGN_RDATA : mem_rdata_i;
  assign pc_rvalid_o = tag_out.vld && (tag_out.src == SRC_PC);
  assign ex_rvalid_o = tag_out.vld && (tag_out.src == SRC_EX);

  // Live data on the strobe cycle, last delivered word otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_hold_q <= '0;
      ex_hold_q <= '0;
    end else begin
      if (pc_rvalid_o) pc_hold_q <= rsp_data;
      if (ex_rvalid_o) ex_hold_q <= rsp_data;
    end
  end

  assign pc_rdata_o = pc_rvalid_o ? rsp_data : pc_hold_q;
  assign ex_rdata_o = ex_rvalid_o ? rsp_data : ex_hold_q;

endmodule

// File: rtl/nib_mem_bridge.sv
// Arbitrates the core's fetch (pc) and load/store (ex) NIB ports onto one
// single-port synchronous RAM; ex has priority, pc is protected from starvation.
module nib_mem_bridge
  import nib_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              nib_pc_req_i,
  input  logic [31:0]       nib_pc_addr_i,
  output logic              nib_pc_ready_o,
  output logic              nib_pc_rvalid_o,
  output logic [31:0]       nib_pc_rdata_o,
  input  logic              nib_ex_req_i,
  input  logic [31:0]       nib_ex_addr_i,
  input  logic              nib_ex_we_i,
  input  logic [31:0]       nib_ex_data_i,
  output logic              nib_ex_ready_o,
  output logic              nib_ex_rvalid_o,
  output logic [31:0]       nib_ex_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              err_o
);

  localparam int               CNT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             pc_force;
  logic             pc_gnt;
  logic             ex_gnt;
  logic             any_gnt;
  logic             misalign;
  logic             err_q;
  logic [31:0]      sel_addr;
  logic             unused_addr_hi;
  tag_t             tag_in;

  // ex wins unless pc has lost MAX_WAIT-1 cycles in a row.
  assign pc_force = nib_pc_req_i && (wait_cnt_q == CNT_MAX);
  assign ex_gnt   = nib_ex_req_i && !pc_force;
  assign pc_gnt   = nib_pc_req_i && !ex_gnt;
  assign any_gnt  = ex_gnt || pc_gnt;

  assign nib_pc_ready_o = pc_gnt;
  assign nib_ex_ready_o = ex_gnt;

  assign sel_addr    = ex_gnt ? nib_ex_addr_i : nib_pc_addr_i;
  assign misalign    = sel_addr[1:0] != 2'b00;
  assign mem_en_o    = any_gnt && !misalign;
  assign mem_we_o    = ex_gnt && nib_ex_we_i && !misalign;
  assign mem_addr_o  = sel_addr[ADDR_W+1:2];
  assign mem_wdata_o = nib_ex_data_i;

  // Bits above the RAM word index are deliberately dropped (address wraps).
  assign unused_addr_hi = ^sel_addr[31:ADDR_W+2];

  always_comb begin
    tag_in      = '0;
    tag_in.vld  = any_gnt && !(ex_gnt && nib_ex_we_i);
    tag_in.src  = ex_gnt ? SRC_EX : SRC_PC;
    tag_in.zero = misalign;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!nib_pc_req_i || pc_gnt) wait_cnt_q <= '0;
      else if (wait_cnt_q != CNT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (any_gnt && misalign) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  nib_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp (
    .clk        (clk),
    .rstn       (rstn),
    .tag_i      (tag_in),
    .mem_rdata_i(mem_rdata_i),
    .pc_rvalid_o(nib_pc_rvalid_o),
    .pc_rdata_o (nib_pc_rdata_o),
    .ex_rvalid_o(nib_ex_rvalid_o),
    .ex_rdata_o (nib_ex_rdata_o)
  );

endmodule

// File: tb/tb_nib_mem_bridge.sv
// Scoreboard bench for nib_mem_bridge: directed scenarios plus random traffic,
// checked against a word-array memory model and rule-level arbitration model.
module tb_nib_mem_bridge;
  localparam int ADDR_W   = 6;
  localparam int RD_LAT   = 3;
  localparam int MAX_WAIT = 5;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic              pc_req = 0, ex_req = 0, ex_we = 0;
  logic [31:0]       pc_addr = 0, ex_addr = 0, ex_data = 0;
  logic              nib_pc_ready_o, nib_pc_rvalid_o, nib_ex_ready_o, nib_ex_rvalid_o;
  logic [31:0]       nib_pc_rdata_o, nib_ex_rdata_o, mem_wdata_o, mem_rdata_i;
  logic              mem_en_o, mem_we_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o;

  nib_mem_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstn(rstn),
    .nib_pc_req_i(pc_req), .nib_pc_addr_i(pc_addr), .nib_pc_ready_o(nib_pc_ready_o),
    .nib_pc_rvalid_o(nib_pc_rvalid_o), .nib_pc_rdata_o(nib_pc_rdata_o),
    .nib_ex_req_i(ex_req), .nib_ex_addr_i(ex_addr), .nib_ex_we_i(ex_we),
    .nib_ex_data_i(ex_data), .nib_ex_ready_o(nib_ex_ready_o),
    .nib_ex_rvalid_o(nib_ex_rvalid_o), .nib_ex_rdata_o(nib_ex_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // External RAM: reloaded while in reset, fixed read latency.
  logic [31:0] ram [DEPTH];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (!rstn) for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    else if (mem_en_o && mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    rd_pipe[0] <= ram[mem_addr_o];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[RD_LAT-1];

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        q [2][$];
  logic [31:0] last [2];
  logic [31:0] shadow [DEPTH];
  int          checks = 0, errors = 0, cyc = 0, wcnt = 0;
  logic        errm = 0, pc_acc = 0, ex_acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: inputs already driven; check the grant and RAM drive, then
  // update the reference (memory, sticky error, starvation count, queues).
  task automatic step();
    logic        fp, eg, pg, mis;
    logic [31:0] a;
    int          w;
    @(negedge clk);
    chk("err_o", 32'(err_o), 32'(errm));
    fp = pc_req && (wcnt == MAX_WAIT - 1);
    eg = ex_req && !fp;
    pg = pc_req && !eg;
    chk("pc_ready", 32'(nib_pc_ready_o), 32'(pg));
    chk("ex_ready", 32'(nib_ex_ready_o), 32'(eg));
    a   = eg ? ex_addr : pc_addr;
    mis = (a % 4) != 0;
    w   = int'((a / 4) % DEPTH);
    chk("mem_en", 32'(mem_en_o), 32'((eg || pg) && !mis));
    chk("mem_we", 32'(mem_we_o), 32'(eg && ex_we && !mis));
    if ((eg || pg) && !mis) chk("mem_addr", 32'(mem_addr_o), 32'(w));
    if (eg && ex_we) begin
      if (!mis) begin
        chk("mem_wdata", mem_wdata_o, ex_data);
        shadow[w] = ex_data;
      end
    end else if (eg || pg) begin
      q[int'(eg)].push_back('{data: mis ? 32'h0 : shadow[w], due: cyc + RD_LAT});
    end
    if ((eg || pg) && mis) errm = 1'b1;
    if (!pc_req || pg) wcnt = 0;
    else if (wcnt < MAX_WAIT - 1) wcnt++;
    pc_acc = pg;
    ex_acc = eg;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic pr, logic [31:0] pa, logic er, logic [31:0] ea,
                       logic ew, logic [31:0] ed);
    pc_req = pr; pc_addr = pa; ex_req = er; ex_addr = ea; ex_we = ew; ex_data = ed;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic model_reset();
    q[0].delete();
    q[1].delete();
    last[0] = 0;
    last[1] = 0;
    errm = 0;
    wcnt = 0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
  endtask

  // Response monitor: every strobe must match the oldest expected entry for
  // that port on its due cycle; rdata must hold between strobes.
  logic        mon_rv;
  logic [31:0] mon_rd;
  rsp_t        mon_r;
  string       mon_pn;
  always @(negedge clk) begin
    if (rstn) begin
      for (int p = 0; p < 2; p++) begin
        mon_rv = (p == 1) ? nib_ex_rvalid_o : nib_pc_rvalid_o;
        mon_rd = (p == 1) ? nib_ex_rdata_o : nib_pc_rdata_o;
        mon_pn = (p == 1) ? "ex" : "pc";
        if (mon_rv) begin
          if (q[p].size() == 0) begin
            chk({mon_pn, "_spurious_rvalid"}, 32'd1, 32'd0);
            last[p] = mon_rd;
          end else begin
            mon_r = q[p].pop_front();
            chk({mon_pn, "_rsp_cycle"}, 32'(cyc), 32'(mon_r.due));
            chk({mon_pn, "_rdata"}, mon_rd, mon_r.data);
            last[p] = mon_r.data;
          end
        end else begin
          chk({mon_pn, "_rdata_hold"}, mon_rd, last[p]);
          if (q[p].size() != 0 && q[p][0].due <= cyc) begin
            chk({mon_pn, "_missing_rvalid"}, 32'd0, 32'd1);
            void'(q[p].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    model_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_pc_rvalid", 32'(nib_pc_rvalid_o), 32'd0);
    chk("rst_ex_rvalid", 32'(nib_ex_rvalid_o), 32'd0);
    chk("rst_pc_rdata", nib_pc_rdata_o, 32'd0);
    chk("rst_ex_rdata", nib_ex_rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Lone fetch, then collision (ex first, pc next cycle).
    drive(1, 32'h10, 0, 0, 0, 0);
    idle(RD_LAT + 1);
    drive(1, 32'h0, 1, 32'h8, 0, 0);
    drive(1, 32'h0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // Starvation: ex requests every cycle, pc must win after MAX_WAIT cycles.
    pc_req = 1; pc_addr = 32'h40; ex_req = 1; ex_we = 0; ex_addr = rnd_addr() & ~32'h3;
    pc_acc = 0;
    n = 0;
    while (!pc_acc && n < MAX_WAIT + 3) begin
      step();
      n++;
      if (ex_acc) ex_addr = rnd_addr() & ~32'h3;
    end
    chk("starve_wait_cycles", 32'(n), 32'(MAX_WAIT));
    pc_req = 0;
    step();
    chk("ex_resume", 32'(ex_acc), 32'd1);
    idle(RD_LAT + 1);

    // Store then load, misaligned read/write, wrapped address.
    drive(0, 0, 1, 32'h20, 1, 32'hCAFE_F00D);
    drive(0, 0, 1, 32'h20, 0, 0);
    idle(RD_LAT + 1);
    drive(0, 0, 1, 32'h3, 0, 0);
    drive(0, 0, 1, 32'h22, 1, 32'hDEAD_BEEF);
    drive(0, 0, 1, 32'h20 + 32'(DEPTH * 4 * 5), 0, 0);
    drive(1, 32'hFFFF_FF21, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // Random traffic with held requests.
    pc_req = 0; ex_req = 0;
    for (int i = 0; i < 600; i++) begin
      if (pc_acc || !pc_req) begin
        pc_req  = ($urandom_range(0, 3) != 0);
        pc_addr = rnd_addr();
      end
      if (ex_acc || !ex_req) begin
        ex_req  = ($urandom_range(0, 3) != 0);
        ex_addr = rnd_addr();
        ex_we   = $urandom_range(0, 1) == 1;
        ex_data = $urandom;
      end
      step();
    end
    idle(RD_LAT + 2);
    chk("drain_pc", 32'(q[0].size()), 32'd0);
    chk("drain_ex", 32'(q[1].size()), 32'd0);

    // Reset with a read in flight: nothing may come back afterwards.
    drive(1, 32'h10, 0, 0, 0, 0);
    pc_req = 0; ex_req = 0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_pc_rvalid", 32'(nib_pc_rvalid_o), 32'd0);
    chk("mid_rst_ex_rvalid", 32'(nib_ex_rvalid_o), 32'd0);
    chk("mid_rst_pc_rdata", nib_pc_rdata_o, 32'd0);
    chk("mid_rst_ex_rdata", nib_ex_rdata_o, 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en_o), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(RD_LAT + 3);
    drive(0, 0, 1, 32'h20, 0, 0);
    idle(RD_LAT + 2);
    chk("final_drain_ex", 32'(q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
